fifo_wr_arbiter: RTL

- Round-robin arbiter that shares the single write port of a FIFO (`wr_en`/`buf_in`/`buf_full`) between NREQ producers.
- Grants one requester at a time for a bounded burst of up to MAX_BURST beats and honours `buf_full` backpressure.
- Provides an enable input so arbitration can be paused.
- Sits in the write-clock domain, directly in front of the FIFO write side.

---
 rtl/fifo_arb_pkg.sv | 25 ++
 rtl/rr_pick.sv | 30 +++
 rtl/fifo_wr_arbiter.sv | 127 ++++++++++++
 3 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types and constants for the FIFO write-port arbiter and its schedulers.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_e;

    localparam int unsigned NREQ_DEF      = 4;
    localparam int unsigned DATA_W_DEF    = 8;
    localparam int unsigned MAX_BURST_DEF = 4;

    // Ceiling log2; returns 0 for v <= 1.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < v) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request above 'last', wrapping modulo NREQ.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int unsigned NREQ = NREQ_DEF,
    parameter int unsigned IW   = clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last,
    output logic [IW-1:0]   winner,
    output logic            valid
);

    logic [IW-1:0] cand;

    // Scan from the farthest offset down so the nearest requester wins.
    always_comb begin
        winner = '0;
        valid  = 1'b0;
        cand   = '0;
        for (int k = int'(NREQ); k >= 1; k--) begin
            cand = IW'((32'(last) + 32'(k)) % NREQ);
            if (req[cand]) begin
                winner = cand;
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NREQ producers,
// granting bounded bursts and honouring buf_full backpressure.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int unsigned NREQ      = NREQ_DEF,
    parameter int unsigned DATA_W    = DATA_W_DEF,
    parameter int unsigned MAX_BURST = MAX_BURST_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     arb_en,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*DATA_W-1:0]   req_data,
    input  logic                     buf_full,
    output logic [NREQ-1:0]          gnt,
    output logic [NREQ-1:0]          ack,
    output logic                     wr_en,
    output logic [DATA_W-1:0]        buf_in,
    output logic [clog2(NREQ)-1:0]   owner,
    output logic                     busy
);

    localparam int unsigned IW = clog2(NREQ);
    localparam int unsigned CW = clog2(MAX_BURST + 1);

    arb_state_e      state_q, state_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic [IW-1:0]   last_q, last_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [CW-1:0]   cnt_inc;
    logic            busy_q, busy_d;

    logic [IW-1:0]     pick_idx;
    logic              pick_valid;
    logic [DATA_W-1:0] data_arr [NREQ];

    for (genvar i = 0; i < int'(NREQ); i++) begin : g_data
        assign data_arr[i] = req_data[i*DATA_W +: DATA_W];
    end

    rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_rr_pick (
        .req    (req),
        .last   (last_q),
        .winner (pick_idx),
        .valid  (pick_valid)
    );

    assign cnt_inc = cnt_q + CW'(1);

    // Next-state and combinational write-port drive.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        owner_d = owner_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        wr_en   = 1'b0;
        buf_in  = '0;
        ack     = '0;

        unique case (state_q)
            IDLE: begin
                gnt_d = '0;
                if (arb_en && pick_valid) begin
                    state_d = BURST;
                    gnt_d   = NREQ'(1) << pick_idx;
                    owner_d = pick_idx;
                    last_d  = pick_idx;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            BURST: begin
                wr_en  = req[owner_q] && !buf_full;
                buf_in = data_arr[owner_q];
                ack    = wr_en ? gnt_q : '0;
                if (!req[owner_q]) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    busy_d  = 1'b0;
                end else if (wr_en) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == CW'(MAX_BURST)) begin
                        state_d = IDLE;
                        gnt_d   = '0;
                        busy_d  = 1'b0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Pointer resets to NREQ-1 so requester 0 wins first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            owner_q <= '0;
            last_q  <= IW'(NREQ - 1);
            cnt_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
        end
    end

    assign gnt   = gnt_q;
    assign owner = owner_q;
    assign busy  = busy_q;

endmodule
